// File: rtl/thread_offset_selector.sv
// rtl/thread_offset_selector.sv - per-thread offset address selector, 2-cycle latency; optional post-increment via THREAD_OFFSET_SELECTOR_INCR_EN
module thread_offset_selector #(
    parameter int WORD_WIDTH        = 10,
    parameter int THREAD_COUNT      = 8,
    parameter int THREAD_ADDR_WIDTH = 3,
    parameter int INCREMENT         = 1
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [WORD_WIDTH-1:0]        addr_in,
    input  logic                         use_raw_addr,
    input  logic                         incr_in,
    input  logic                         offset_wren,
    input  logic [THREAD_ADDR_WIDTH-1:0] offset_wr_thread,
    input  logic [WORD_WIDTH-1:0]        offset_wr_data,
    output logic [WORD_WIDTH-1:0]        addr_out,
    output logic [THREAD_ADDR_WIDTH-1:0] thread_out
);

    localparam logic [THREAD_ADDR_WIDTH-1:0] LAST_THR = THREAD_ADDR_WIDTH'(THREAD_COUNT - 1);

    logic [THREAD_ADDR_WIDTH-1:0] r_thr;
    logic [WORD_WIDTH-1:0]        r_offset [THREAD_COUNT];
    logic [WORD_WIDTH-1:0]        w_cur_offset;

    logic [WORD_WIDTH-1:0]        r_raw;
    logic [WORD_WIDTH-1:0]        r_sum;
    logic                         r_sel;
    logic [THREAD_ADDR_WIDTH-1:0] r_t1;

    logic [WORD_WIDTH-1:0]        r_addr_out;
    logic [THREAD_ADDR_WIDTH-1:0] r_thread_out;

`ifdef THREAD_OFFSET_SELECTOR_INCR_EN
    localparam logic [WORD_WIDTH-1:0] INCR_STEP = WORD_WIDTH'(INCREMENT);
    logic w_incr_en;
    assign w_incr_en = incr_in && !use_raw_addr;
`else
    logic w_unused_incr;
    assign w_unused_incr = incr_in;
`endif

    // Stage-1 read sees the offset as it stood before this cycle's update
    assign w_cur_offset = r_offset[r_thr];

    // Round-robin thread slot, wraps at THREAD_COUNT-1
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_thr <= '0;
        end else if (r_thr == LAST_THR) begin
            r_thr <= '0;
        end else begin
            r_thr <= r_thr + 1'b1;
        end
    end

    // Offset registers; the external write is applied last so it overrides an increment to the same thread
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < THREAD_COUNT; i++) begin
                r_offset[i] <= '0;
            end
        end else begin
            for (int i = 0; i < THREAD_COUNT; i++) begin
`ifdef THREAD_OFFSET_SELECTOR_INCR_EN
                if (w_incr_en && (r_thr == THREAD_ADDR_WIDTH'(i))) begin
                    r_offset[i] <= r_offset[i] + INCR_STEP;
                end
`endif
                if (offset_wren && (offset_wr_thread == THREAD_ADDR_WIDTH'(i))) begin
                    r_offset[i] <= offset_wr_data;
                end
            end
        end
    end

    // Stage 1: capture raw address, offset sum, selector and thread slot
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_raw <= '0;
            r_sum <= '0;
            r_sel <= 1'b0;
            r_t1  <= '0;
        end else begin
            r_raw <= addr_in;
            r_sum <= addr_in + w_cur_offset;
            r_sel <= use_raw_addr;
            r_t1  <= r_thr;
        end
    end

    // Stage 2: pick raw or offset address, carry thread index alongside
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_addr_out   <= '0;
            r_thread_out <= '0;
        end else begin
            r_addr_out   <= r_sel ? r_raw : r_sum;
            r_thread_out <= r_t1;
        end
    end

    assign addr_out   = r_addr_out;
    assign thread_out = r_thread_out;

endmodule

// File: tb/tb_thread_offset_selector.sv
// tb/tb_thread_offset_selector.sv - self-checking bench for thread_offset_selector
module tb_thread_offset_selector;

    localparam int WW  = 10;
    localparam int TC  = 8;
    localparam int TAW = 3;
    localparam int INC = 1;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic [WW-1:0]  addr_in = '0;
    logic           use_raw_addr = 1'b0;
    logic           incr_in = 1'b0;
    logic           offset_wren = 1'b0;
    logic [TAW-1:0] offset_wr_thread = '0;
    logic [WW-1:0]  offset_wr_data = '0;
    logic [WW-1:0]  addr_out;
    logic [TAW-1:0] thread_out;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;
    bit incr_always = 1'b0;
    int idle_cnt = 0;

`ifdef THREAD_OFFSET_SELECTOR_INCR_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif

    thread_offset_selector #(
        .WORD_WIDTH(WW), .THREAD_COUNT(TC), .THREAD_ADDR_WIDTH(TAW), .INCREMENT(INC)
    ) dut (
        .clock(clock), .reset_n(reset_n), .addr_in(addr_in), .use_raw_addr(use_raw_addr),
        .incr_in(incr_in), .offset_wren(offset_wren), .offset_wr_thread(offset_wr_thread),
        .offset_wr_data(offset_wr_data), .addr_out(addr_out), .thread_out(thread_out)
    );

    always #5 clock = ~clock;

    // Reference model: final address computed at input time, then delayed by two slots
    int m_thr = 0;
    int m_off [TC];
    int m_p1_addr = 0, m_p1_thr = 0;
    int m_out_addr = 0, m_out_thr = 0;

    always @(posedge clock) begin
        if (!reset_n) begin
            m_thr = 0;
            for (int i = 0; i < TC; i++) m_off[i] = 0;
            m_p1_addr = 0; m_p1_thr = 0;
            m_out_addr = 0; m_out_thr = 0;
        end else begin
            m_out_addr = m_p1_addr;
            m_out_thr  = m_p1_thr;
            m_p1_addr  = use_raw_addr ? int'(addr_in) : (int'(addr_in) + m_off[m_thr]) % (1 << WW);
            m_p1_thr   = m_thr;
            if (FEAT && incr_in && !use_raw_addr)
                m_off[m_thr] = (m_off[m_thr] + INC) % (1 << WW);
            if (offset_wren && int'(offset_wr_thread) < TC)
                m_off[offset_wr_thread] = int'(offset_wr_data);
            m_thr = (m_thr + 1) % TC;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clock) begin
        if (chk_en) begin
            vectors++;
            if (int'(addr_out) != m_out_addr || int'(thread_out) != m_out_thr) begin
                miscompares++;
                $display("FAIL cycle_cmp t=%0t: got addr=%03h thr=%0d, expected addr=%03h thr=%0d",
                         $time, addr_out, thread_out, m_out_addr, m_out_thr);
            end
        end
    end

    task automatic lit(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [WW-1:0] a, input logic raw, input logic inc,
                         input logic wen, input logic [TAW-1:0] wt, input logic [WW-1:0] wd);
        addr_in = a; use_raw_addr = raw; incr_in = inc;
        offset_wren = wen; offset_wr_thread = wt; offset_wr_data = wd;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        idle_cnt++;
        drive(WW'((idle_cnt * 37 + 11) % (1 << WW)), 1'b0, incr_always, 1'b0, '0, '0);
    endtask

    task automatic goto_slot(input int t);
        int guard = 0;
        while (m_thr != t && guard < 2 * TC) begin
            idle();
            guard++;
        end
        if (m_thr != t) lit("goto_slot_timeout", m_thr, t);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset
        reset_n = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk_en = 1'b1;
        lit("reset_addr_out", int'(addr_out), 0);
        lit("reset_thread_out", int'(thread_out), 0);
        reset_n = 1'b1;

        // offset[3]=0x010, thread-3 access with addr 0x005
        drive(10'h000, 1'b0, 1'b0, 1'b1, 3'd3, 10'h010);
        goto_slot(3);
        drive(10'h005, 1'b0, 1'b0, 1'b0, '0, '0);
        idle();
        lit("t1_offset_addr", int'(addr_out), 'h015);
        lit("t1_thread", int'(thread_out), 3);

        // raw bypass while offset[6]=0x050
        drive(10'h000, 1'b0, 1'b0, 1'b1, 3'd6, 10'h050);
        goto_slot(6);
        drive(10'h123, 1'b1, 1'b0, 1'b0, '0, '0);
        idle();
        lit("t2_raw_addr", int'(addr_out), 'h123);
        lit("t2_thread", int'(thread_out), 6);

        // Write and increment to thread 5 in the same cycle: write wins
        goto_slot(5);
        drive(10'h000, 1'b0, 1'b1, 1'b1, 3'd5, 10'h040);
        goto_slot(5);
        drive(10'h000, 1'b0, 1'b0, 1'b0, '0, '0);
        idle();
        lit("t4_write_wins", int'(addr_out), 'h040);

`ifdef THREAD_OFFSET_SELECTOR_INCR_EN
        // Post-increment wrap on thread 2
        drive(10'h000, 1'b0, 1'b0, 1'b1, 3'd2, 10'h3FE);
        goto_slot(2);
        drive(10'h001, 1'b0, 1'b1, 1'b0, '0, '0);
        idle();
        lit("t3_incr_a", int'(addr_out), 'h3FF);
        goto_slot(2);
        drive(10'h001, 1'b0, 1'b1, 1'b0, '0, '0);
        idle();
        lit("t3_incr_b", int'(addr_out), 'h000);
        goto_slot(2);
        drive(10'h001, 1'b0, 1'b1, 1'b0, '0, '0);
        idle();
        lit("t3_incr_c", int'(addr_out), 'h001);
        lit("t3_model_off2", m_off[2], 'h001);
        goto_slot(2);
        drive(10'h000, 1'b0, 1'b0, 1'b0, '0, '0);
        idle();
        lit("t3_off2_final", int'(addr_out), 'h001);

        // Increment on thread 1 while writing thread 7: both take effect
        drive(10'h000, 1'b0, 1'b0, 1'b1, 3'd1, 10'h100);
        goto_slot(1);
        drive(10'h000, 1'b0, 1'b1, 1'b1, 3'd7, 10'h0AA);
        goto_slot(1);
        drive(10'h000, 1'b0, 1'b0, 1'b0, '0, '0);
        idle();
        lit("t5_incr_other", int'(addr_out), 'h101);
        goto_slot(7);
        drive(10'h001, 1'b0, 1'b0, 1'b0, '0, '0);
        idle();
        lit("t5_write_other", int'(addr_out), 'h0AB);

        // incr ignored on raw access
        goto_slot(3);
        drive(10'h000, 1'b1, 1'b1, 1'b0, '0, '0);
        goto_slot(3);
        drive(10'h005, 1'b0, 1'b0, 1'b0, '0, '0);
        idle();
        lit("t6_raw_no_incr", int'(addr_out), 'h015);
`else
        // incr_in held high for two full rounds: offsets must not move
        incr_always = 1'b1;
        for (int i = 0; i < 2 * TC; i++) idle();
        goto_slot(3);
        drive(10'h005, 1'b0, 1'b1, 1'b0, '0, '0);
        idle();
        lit("t6_no_incr_off3", int'(addr_out), 'h015);
        goto_slot(6);
        drive(10'h100, 1'b0, 1'b1, 1'b0, '0, '0);
        idle();
        lit("t6_no_incr_off6", int'(addr_out), 'h150);
        incr_always = 1'b0;
`endif

        // Mid-stream reset with nonzero offsets
        goto_slot(4);
        reset_n = 1'b0;
        idle();
        lit("t7_rst_addr", int'(addr_out), 0);
        lit("t7_rst_thread", int'(thread_out), 0);
        reset_n = 1'b1;
        drive(10'h2A0, 1'b0, 1'b0, 1'b0, '0, '0);
        idle();
        lit("t7_first_thread", int'(thread_out), 0);
        lit("t7_first_addr", int'(addr_out), 'h2A0);
        goto_slot(3);
        drive(10'h005, 1'b0, 1'b0, 1'b0, '0, '0);
        idle();
        lit("t7_off3_cleared", int'(addr_out), 'h005);
        goto_slot(6);
        drive(10'h123, 1'b0, 1'b0, 1'b0, '0, '0);
        idle();
        lit("t7_off6_cleared", int'(addr_out), 'h123);
        idle();
        idle();

        chk_en = 1'b0;
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/thread_offset_selector.md
Name: thread_offset_selector

Overview:
- Per-thread successor to the single-offset address selector.
- Holds one programmable offset per hardware thread and tracks the round-robin thread slot internally.
- Each cycle, either passes the raw address or adds the current thread's offset, with optional post-increment of that offset.
- Sits in the operand addressing stage, feeding memory read/write addresses, with a fixed 2-cycle latency.

Parameters:
- WORD_WIDTH, 10: width of addresses and offsets.
- THREAD_COUNT, 8: number of round-robin threads; must be >= 2.
- THREAD_ADDR_WIDTH, 3: clog2(THREAD_COUNT); width of thread indices.
- INCREMENT, 1: stride added to a thread's offset on post-increment. Modulo 2^WORD_WIDTH.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- addr_in  in  WORD_WIDTH  raw address for the current thread slot.
- use_raw_addr  in  1  1 = output addr_in unchanged; 0 = output addr_in + offset[thread].
- incr_in  in  1  post-increment request for the current thread's offset.
- offset_wren  in  1  external offset write enable.
- offset_wr_thread  in  THREAD_ADDR_WIDTH  thread whose offset is written.
- offset_wr_data  in  WORD_WIDTH  new offset value.
- addr_out  out  WORD_WIDTH  selected address, 2 cycles after its inputs.
- thread_out  out  THREAD_ADDR_WIDTH  thread index aligned with addr_out.

Behaviour:
- Thread counter
  - Internal thread counter `thr` resets to 0.
  - Increments every cycle and wraps from THREAD_COUNT-1 to 0.
  - Inputs sampled in cycle N belong to thread thr(N).
- Pipeline
  - Stage 1 (edge after cycle N) registers:
    - raw = addr_in
    - sum = addr_in + offset[thr], truncated to WORD_WIDTH, no carry out
    - sel = use_raw_addr
    - t1 = thr
  - Stage 2 registers:
    - addr_out = sel ? raw : sum
    - thread_out = t1
  - Latency is exactly 2 cycles, with one result per cycle and no stalls.
- Offset storage
  - THREAD_COUNT x WORD_WIDTH registers, all reset to 0.
  - The read for stage 1 uses the value held before any update in the same cycle (no forwarding).
- External write
  - When offset_wren=1, offset[offset_wr_thread] takes offset_wr_data at the edge.
  - If offset_wr_thread is out of range (>= THREAD_COUNT), the write is ignored.
- Post-increment (feature enabled)
  - When incr_in=1 and use_raw_addr=0 in cycle N, offset[thr(N)] becomes old+INCREMENT at the edge.
  - incr_in is ignored when use_raw_addr=1.
- Simultaneous events
  - External write and post-increment to the same thread in the same cycle: the external write wins and the increment is dropped.
  - Writes or increments to different threads in the same cycle both take effect.
- Wrap-around
  - Sums and increments wrap modulo 2^WORD_WIDTH, with no saturation or flags.
- Reset
  - reset_n=0 at an edge clears thr, all offsets, both pipeline stages, addr_out and thread_out to 0.
  - In-flight results are discarded, and writes or increments in the reset cycle are ignored.
  - After release, the first valid addr_out (thread 0) appears 2 cycles after the first post-reset input cycle.

Optional Feature:
- Macro: THREAD_OFFSET_SELECTOR_INCR_EN.
- Defined: post-increment logic is present, behaving as above.
- Undefined:
  - The incr_in port still exists but is ignored, and no increment adder is built.
  - Offsets change only via external writes or reset.

Test Plan:
- Reset, then write offset[3]=0x010. Drive addr_in=0x005, use_raw_addr=0 in thread 3's slot -> addr_out=0x015 and thread_out=3 exactly 2 cycles later; other threads with offset 0 return addr_in.
- Set use_raw_addr=1 with addr_in=0x123 while offset[thr]=0x050 -> addr_out=0x123 after 2 cycles.
- With feature enabled, INCREMENT=1, offset[2]=0x3FE, WORD_WIDTH=10: issue incr_in=1, use_raw_addr=0, addr_in=0x001 in three consecutive thread-2 slots -> addr_out 0x3FF, 0x000, 0x001, and offset[2] ends at 0x001 (wrap).
- Same cycle as thread 5 slot: incr_in=1 plus offset_wren=1, offset_wr_thread=5, data 0x040 -> offset[5]=0x040, not old+1. Next thread-5 access with addr_in=0 -> addr_out=0x040.
- Assert reset_n=0 for one cycle mid-stream with nonzero offsets -> next edge addr_out=0, thread_out=0, all offsets 0, thread counter restarts at 0.
- With feature disabled: incr_in=1 on every cycle -> offsets unchanged and addr_out equals addr_in+programmed offset every time.
